// File: rtl/target_mem_window_if.sv
// Bus-side signal bundle for target_mem_window.
// The master drives address/data strobes; the slave answers with data, ack, ready and err.
interface target_mem_window_if #(
  parameter int DATA_WIDTH = 8
);
  logic [15:0]           target_addr_in;
  logic                  target_addr_in_valid;
  logic [DATA_WIDTH-1:0] target_data_in;
  logic                  target_data_in_valid;
  logic                  target_rw;
  logic [DATA_WIDTH-1:0] target_data_out;
  logic                  target_data_out_valid;
  logic                  target_ack;
  logic                  target_ready;
  logic [DATA_WIDTH-1:0] target_last_write;
  logic                  target_err;

  modport master (
    output target_addr_in, target_addr_in_valid,
    output target_data_in, target_data_in_valid, target_rw,
    input  target_data_out, target_data_out_valid,
    input  target_ack, target_ready, target_last_write, target_err
  );

  modport slave (
    input  target_addr_in, target_addr_in_valid,
    input  target_data_in, target_data_in_valid, target_rw,
    output target_data_out, target_data_out_valid,
    output target_ack, target_ready, target_last_write, target_err
  );
endinterface

// File: rtl/target_mem_window.sv
// Windowed register-array bus target with read wait states and split-write timeout.
// Define TARGET_ERR_RESP_EN to pulse target_err on misses, busy strobes and timeouts.
module target_mem_window #(
  parameter int          DATA_WIDTH         = 8,
  parameter int          INTERNAL_ADDR_BITS = 4,
  parameter logic [15:0] BASE_ADDR          = 16'h0000,
  parameter int          READ_LATENCY       = 0,
  parameter int          WR_TIMEOUT         = 16
) (
  input logic               clk,
  input logic               rst,
  target_mem_window_if.slave bus
);

  localparam int IAB   = INTERNAL_ADDR_BITS;
  localparam int DEPTH = 1 << IAB;
  localparam int RLW   = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int TOW   = (WR_TIMEOUT > 0) ? $clog2(WR_TIMEOUT + 1) : 1;
  localparam logic [TOW-1:0] TMO_LAST =
    (WR_TIMEOUT > 0) ? TOW'(WR_TIMEOUT - 1) : '0;

`ifdef TARGET_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [IAB-1:0]        idx_q, idx_d;
  logic [RLW-1:0]        rcnt_q, rcnt_d;
  logic [TOW-1:0]        tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic                  dval_q, dval_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic [IAB-1:0]        waddr;
  logic                  err_evt;

  logic           hit;
  logic [IAB-1:0] idx_in;

  assign hit    = bus.target_addr_in[15:IAB] == BASE_ADDR[15:IAB];
  assign idx_in = bus.target_addr_in[IAB-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    tmr_d   = tmr_q;
    rdat_d  = rdat_q;
    dout_d  = dout_q;
    last_d  = last_q;
    dval_d  = 1'b0;
    ack_d   = 1'b0;
    err_evt = 1'b0;
    we      = 1'b0;
    waddr   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.target_addr_in_valid) begin
          if (!hit) begin
            err_evt = 1'b1;
          end else if (bus.target_rw) begin
            if (bus.target_data_in_valid) begin
              we     = 1'b1;
              waddr  = idx_in;
              last_d = bus.target_data_in;
              ack_d  = 1'b1;
            end else begin
              idx_d   = idx_in;
              tmr_d   = '0;
              state_d = WR_WAIT;
            end
          end else if (READ_LATENCY == 0) begin
            dout_d = mem[idx_in];
            dval_d = 1'b1;
            ack_d  = 1'b1;
          end else begin
            rdat_d  = mem[idx_in];
            rcnt_d  = RLW'(READ_LATENCY);
            state_d = RD_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (bus.target_addr_in_valid) err_evt = 1'b1;
        // data in the expiry cycle still completes the write
        if (bus.target_data_in_valid) begin
          we      = 1'b1;
          last_d  = bus.target_data_in;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else if (WR_TIMEOUT != 0) begin
          if (tmr_q == TMO_LAST) begin
            err_evt = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (bus.target_addr_in_valid) err_evt = 1'b1;
        if (rcnt_q <= RLW'(1)) begin
          rcnt_d  = '0;
          dout_d  = rdat_q;
          dval_d  = 1'b1;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = ERR_EN && err_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rcnt_q  <= '0;
      tmr_q   <= '0;
      rdat_q  <= '0;
      dout_q  <= '0;
      last_q  <= '0;
      dval_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      tmr_q   <= tmr_d;
      rdat_q  <= rdat_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
      dval_q  <= dval_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // storage is never cleared; reset only blocks new writes
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= bus.target_data_in;
  end

  assign bus.target_ready          = (state_q == IDLE);
  assign bus.target_data_out       = dout_q;
  assign bus.target_data_out_valid = dval_q;
  assign bus.target_ack            = ack_q;
  assign bus.target_last_write     = last_q;
  assign bus.target_err            = err_q;

endmodule

// File: tb/tb_target_mem_window.sv
// Randomized scoreboard bench for target_mem_window.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_target_mem_window;
  localparam int DW  = 8;
  localparam int IAB = 4;
  localparam int RL  = 3;
  localparam int TMO = 4;
  localparam logic [15:0] BASE    = 16'h0100;
  localparam logic [11:0] BASE_HI = 12'h010;

`ifdef TARGET_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  target_mem_window_if #(.DATA_WIDTH(DW)) bus ();

  target_mem_window #(
    .DATA_WIDTH(DW),
    .INTERNAL_ADDR_BITS(IAB),
    .BASE_ADDR(BASE),
    .READ_LATENCY(RL),
    .WR_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit            is_rd;
    bit            known;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  bit   errexp [8192];
  bit   busyexp[8192];
  logic [DW-1:0] mdl[16];
  bit   known[16];
  bit   mon_en = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL resp_missing actual=none required=cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.target_ack || bus.target_data_out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp cycle=%0d actual=ack%0b/valid%0b required=none",
                   cyc, bus.target_ack, bus.target_data_out_valid);
        end else begin
          mon_e = q.pop_front();
          chk("resp_cycle", cyc, mon_e.cyc);
          chk("ack", bus.target_ack, 1);
          chk("valid", bus.target_data_out_valid, mon_e.is_rd);
          if (mon_e.is_rd && mon_e.known)
            chk("rd_data", bus.target_data_out, mon_e.data);
          if (!mon_e.is_rd)
            chk("last_write", bus.target_last_write, mon_e.data);
        end
      end
      if (mon_en) begin
        chk("ready", bus.target_ready, !busyexp[cyc]);
        chk("err", bus.target_err, ERR_EN && errexp[cyc]);
      end
    end
  end

  function automatic logic [15:0] hit_addr(int idx);
    return {BASE_HI, 4'(idx)};
  endfunction

  function automatic logic [15:0] miss_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a[15:4] == BASE_HI) a[9] = ~a[9];
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.target_addr_in_valid = 1'b0;
    bus.target_data_in_valid = 1'b0;
    bus.target_addr_in       = 16'($urandom);
    bus.target_data_in       = DW'($urandom);
    bus.target_rw            = 1'($urandom);
  endtask

  task automatic gap(int n);
    repeat (n) step();
  endtask

  task automatic strobe_maybe();
    if ($urandom_range(0, 2) == 0) begin
      bus.target_addr_in_valid = 1'b1;
      errexp[cyc + 1] = 1'b1;
    end
  endtask

  task automatic do_write(int idx, logic [DW-1:0] d, int k);
    int c;
    int n;
    step();
    bus.target_addr_in       = hit_addr(idx);
    bus.target_rw            = 1'b1;
    bus.target_addr_in_valid = 1'b1;
    c = cyc;
    if (k == 0) begin
      bus.target_data_in_valid = 1'b1;
      bus.target_data_in       = d;
      mdl[idx]   = d;
      known[idx] = 1'b1;
      q.push_back('{is_rd: 1'b0, known: 1'b1, data: d, cyc: c + 1});
    end else begin
      n = (k <= TMO) ? k : TMO;
      for (int j = 1; j <= n; j++) begin
        busyexp[c + j] = 1'b1;
        step();
        strobe_maybe();
        if (j == k) begin
          bus.target_data_in_valid = 1'b1;
          bus.target_data_in       = d;
        end
      end
      if (k <= TMO) begin
        mdl[idx]   = d;
        known[idx] = 1'b1;
        q.push_back('{is_rd: 1'b0, known: 1'b1, data: d, cyc: c + k + 1});
      end else begin
        errexp[c + TMO + 1] = 1'b1;
        step();
        bus.target_data_in_valid = 1'b1;
        bus.target_data_in       = d;
      end
    end
  endtask

  task automatic do_read(int idx);
    int c;
    step();
    bus.target_addr_in       = hit_addr(idx);
    bus.target_rw            = 1'b0;
    bus.target_addr_in_valid = 1'b1;
    c = cyc;
    q.push_back('{is_rd: 1'b1, known: known[idx], data: mdl[idx], cyc: c + 1 + RL});
    for (int j = 1; j <= RL; j++) begin
      busyexp[c + j] = 1'b1;
      step();
      strobe_maybe();
    end
  endtask

  task automatic do_miss();
    step();
    bus.target_addr_in       = miss_addr();
    bus.target_addr_in_valid = 1'b1;
    bus.target_data_in_valid = 1'($urandom);
    errexp[cyc + 1] = 1'b1;
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_ready"}, bus.target_ready, 1);
    chk({tag, "_ack"}, bus.target_ack, 0);
    chk({tag, "_valid"}, bus.target_data_out_valid, 0);
    chk({tag, "_err"}, bus.target_err, 0);
    chk({tag, "_dout"}, bus.target_data_out, 0);
    chk({tag, "_last"}, bus.target_last_write, 0);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.target_addr_in       = '0;
    bus.target_addr_in_valid = 1'b0;
    bus.target_data_in       = '0;
    bus.target_data_in_valid = 1'b0;
    bus.target_rw            = 1'b0;
    #12;
    check_reset_outs("por");
    @(negedge clk);
    rst = 1'b0;

    do_write(5, 8'hA5, 0);
    do_read(5);
    do_write(3, 8'h3C, 3);
    do_read(3);
    do_write(5, 8'h11, 0);
    step();
    bus.target_addr_in       = 16'h0205;
    bus.target_rw            = 1'b1;
    bus.target_addr_in_valid = 1'b1;
    bus.target_data_in_valid = 1'b1;
    bus.target_data_in       = 8'h22;
    errexp[cyc + 1] = 1'b1;
    do_read(5);
    do_write(2, 8'h5A, 0);
    do_write(2, 8'h77, TMO + 2);
    do_read(2);
    do_write(4, 8'h44, TMO);
    do_read(4);

    repeat (200) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2)      do_write($urandom_range(0, 15), DW'($urandom), 0);
      else if (op <= 4) do_write($urandom_range(0, 15), DW'($urandom),
                                 $urandom_range(1, TMO + 2));
      else if (op <= 7) do_read($urandom_range(0, 15));
      else if (op == 8) do_miss();
      else              gap($urandom_range(1, 3));
    end
    gap(RL + 3);

    do_write(2, 8'h5A, 0);
    do_read(4);
    gap(RL + 2);
    mon_en = 1'b0;

    step();
    bus.target_addr_in       = hit_addr(2);
    bus.target_rw            = 1'b1;
    bus.target_addr_in_valid = 1'b1;
    step();
    step();
    #1 rst = 1'b1;
    #1 check_reset_outs("rst_wr");
    release_rst();
    step();
    bus.target_data_in_valid = 1'b1;
    bus.target_data_in       = 8'hEE;
    gap(4);

    step();
    bus.target_addr_in       = hit_addr(4);
    bus.target_rw            = 1'b0;
    bus.target_addr_in_valid = 1'b1;
    step();
    #1 rst = 1'b1;
    #1 check_reset_outs("rst_rd");
    release_rst();
    gap(6);
    mon_en = 1'b1;

    do_read(2);
    gap(RL + 3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
